netapp_tx_arbiter: RTL and testbench

//  Frame-atomic 2:1 arbiter that shares the single 256-bit egress AXI-Stream between switch passthrough traffic (port 0)
//  and the locally generated UDP sample-frame stream (port 1). Sits between the netapp frame generator / switch datapath
//  and the output queue. Round-robin between ports at frame granularity; beats of two frames never interleave.

---
 rtl/netapp_tx_arbiter_if.sv | 23 ++
 rtl/netapp_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_netapp_tx_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/netapp_tx_arbiter_if.sv
// AXI-Stream bundle (data, keep, user, valid, ready, last) shared by the arbiter's
// ingress and egress ports.
interface netapp_tx_arbiter_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/netapp_tx_arbiter.sv
// Frame-atomic 2:1 round-robin AXI-Stream arbiter (port 0 passthrough, port 1 local UDP) with one
// registered output stage. Optional post-frame idle gap is compiled in with NETAPP_ARB_GAP_EN.
module netapp_tx_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int GAP_CYCLES         = 4
) (
    input  logic                  axis_aclk,
    input  logic                  axis_resetn,
    netapp_tx_arbiter_if.slave    s0_axis,
    netapp_tx_arbiter_if.slave    s1_axis,
    netapp_tx_arbiter_if.master   m_axis,
    output logic [1:0]            grant
);
    localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

`ifdef NETAPP_ARB_GAP_EN
    localparam int         GAP_EFF  = GAP_CYCLES;
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
    logic [7:0] gap_q;
    logic [7:0] gap_d;
`else
    // Gap length collapses to zero when the feature is compiled out.
    localparam int GAP_EFF = 0 * GAP_CYCLES;
`endif
    localparam logic [1:0] ST_FRAME_END = (GAP_EFF > 0) ? ST_GAP : ST_IDLE;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       last_grant_q;
    logic       last_grant_d;

    logic [C_AXIS_DATA_WIDTH-1:0]  tdata_q;
    logic [KEEP_W-1:0]             tkeep_q;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q;
    logic                          tvalid_q;
    logic                          tlast_q;

    logic                          out_free;
    logic                          s0_ready;
    logic                          s1_ready;
    logic                          load;
    logic                          sel_port1;
    logic [C_AXIS_DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_W-1:0]             sel_keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] sel_user;
    logic                          sel_last;

    // The output stage can take a beat when it is empty or being drained this cycle.
    assign out_free  = !tvalid_q || m_axis.tready;
    assign s0_ready  = (state_q == ST_OWN0) && out_free;
    assign s1_ready  = (state_q == ST_OWN1) && out_free;
    assign load      = (s0_axis.tvalid && s0_ready) || (s1_axis.tvalid && s1_ready);

    assign sel_port1 = (state_q == ST_OWN1);
    assign sel_data  = sel_port1 ? s1_axis.tdata : s0_axis.tdata;
    assign sel_keep  = sel_port1 ? s1_axis.tkeep : s0_axis.tkeep;
    assign sel_user  = sel_port1 ? s1_axis.tuser : s0_axis.tuser;
    assign sel_last  = sel_port1 ? s1_axis.tlast : s0_axis.tlast;

    assign s0_axis.tready = s0_ready;
    assign s1_axis.tready = s1_ready;
    assign grant          = {state_q == ST_OWN1, state_q == ST_OWN0};

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
`ifdef NETAPP_ARB_GAP_EN
        gap_d        = gap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // On a tie the port that did not send the previous frame wins.
                if (s0_axis.tvalid && s1_axis.tvalid) begin
                    state_d = last_grant_q ? ST_OWN0 : ST_OWN1;
                end else if (s0_axis.tvalid) begin
                    state_d = ST_OWN0;
                end else if (s1_axis.tvalid) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (load && sel_last) begin
                    last_grant_d = sel_port1;
                    state_d      = ST_FRAME_END;
`ifdef NETAPP_ARB_GAP_EN
                    gap_d        = GAP_LOAD;
`endif
                end
            end
            default: begin
`ifdef NETAPP_ARB_GAP_EN
                if (gap_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
`ifdef NETAPP_ARB_GAP_EN
            gap_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
`ifdef NETAPP_ARB_GAP_EN
            gap_q        <= gap_d;
`endif
        end
    end

    // Egress register: load on accept, empty when drained, otherwise hold.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load) begin
            tdata_q  <= sel_data;
            tkeep_q  <= sel_keep;
            tuser_q  <= sel_user;
            tvalid_q <= 1'b1;
            tlast_q  <= sel_last;
        end else if (m_axis.tready) begin
            tvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_netapp_tx_arbiter.sv
// Self-checking bench for netapp_tx_arbiter: random frames on both ports, egress compared against
// a frame-level reference (round-robin order or per-port FIFO order) plus handshake rules.
module tb_netapp_tx_arbiter;
    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int KW  = DW / 8;
    localparam int GAP = 3;
`ifdef NETAPP_ARB_GAP_EN
    localparam int EXP_BUBBLE = GAP + 1;
`else
    localparam int EXP_BUBBLE = 1;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;

    netapp_tx_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s0_if ();
    netapp_tx_arbiter_if #(.DATA_W(DW), .USER_W(UW)) s1_if ();
    netapp_tx_arbiter_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

    netapp_tx_arbiter #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .GAP_CYCLES        (GAP)
    ) dut (
        .axis_aclk  (clk),
        .axis_resetn(rst_n),
        .s0_axis    (s0_if),
        .s1_axis    (s1_if),
        .m_axis     (m_if),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];
    bit    pres0, pres1;
    int    gap0_pct, gap1_pct, rdy_pct;
    int    pause_at0, pause_len0, pause_cnt0;
    int    sent0, sent1;
    int    proto_bad, stall_chk, stall_bad;
    int    s0_last_cyc, s1_first_cyc;
    logic [1:0] first_grant1;
    int    open_port;

    function automatic beat_t cur_m();
        return beat_t'({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast});
    endfunction

    function automatic beat_t mk_beat(input int port, input int f, input int b, input bit last);
        beat_t r;
        logic [KW-1:0] ones;
        ones = '1;
        for (int k = 0; k < DW / 32; k++) r.data[k*32 +: 32] = $urandom();
        for (int k = 0; k < UW / 32; k++) r.user[k*32 +: 32] = $urandom();
        r.user[UW-1]  = port[0];
        r.user[15:0]  = {8'(f), 8'(b)};
        r.keep        = last ? (ones >> $urandom_range(0, KW - 1)) : ones;
        r.last        = last;
        return r;
    endfunction

    task automatic gen_frame(input int port, input int f, input int len, input bit to_exp);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk_beat(port, f, i, i == len - 1);
            if (port == 0) q0.push_back(b);
            else           q1.push_back(b);
            if (to_exp) exp_q.push_back(b);
        end
    endtask

    task automatic drive_ports();
        s0_if.tvalid = pres0;
        if (pres0) {s0_if.tdata, s0_if.tkeep, s0_if.tuser, s0_if.tlast} = q0[0];
        s1_if.tvalid = pres1;
        if (pres1) {s1_if.tdata, s1_if.tkeep, s1_if.tuser, s1_if.tlast} = q1[0];
    endtask

    task automatic clear_bench();
        q0.delete(); q1.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete();
        pres0 = 0; pres1 = 0;
        gap0_pct = 0; gap1_pct = 0; rdy_pct = 100;
        pause_at0 = -1; pause_len0 = 0; pause_cnt0 = 0;
        s0_if.tvalid = 0; s0_if.tdata = '0; s0_if.tkeep = '0; s0_if.tuser = '0; s0_if.tlast = 0;
        s1_if.tvalid = 0; s1_if.tdata = '0; s1_if.tkeep = '0; s1_if.tuser = '0; s1_if.tlast = 0;
        m_if.tready  = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_bench();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle engine: AXIS sources with optional valid gaps, a sink with a ready pattern,
    // and a monitor gathering egress beats and handshake-rule violations.
    task automatic run_cycles(input int max_cyc, input int n_beats);
        beat_t held;
        bit    hold_prev, acc0, acc1;
        held = '0; hold_prev = 0;
        got_q.delete(); got_cyc.delete();
        proto_bad = 0; stall_chk = 0; stall_bad = 0; open_port = -1;
        sent0 = 0; sent1 = 0; s0_last_cyc = -1; s1_first_cyc = -1; first_grant1 = 2'b00;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (s0_if.tready && s1_if.tready) proto_bad++;
            if (s0_if.tready && grant !== 2'b01) proto_bad++;
            if (s1_if.tready && grant !== 2'b10) proto_bad++;
            if (open_port == 0 && s1_if.tready) proto_bad++;
            if (open_port == 1 && s0_if.tready) proto_bad++;
            if (hold_prev) begin
                stall_chk++;
                if (m_if.tvalid !== 1'b1 || cur_m() !== held) stall_bad++;
            end
            hold_prev = m_if.tvalid && !m_if.tready;
            held      = cur_m();
            if (m_if.tvalid && m_if.tready) begin
                got_q.push_back(cur_m());
                got_cyc.push_back(cyc);
            end
            acc0 = pres0 && s0_if.tready;
            acc1 = pres1 && s1_if.tready;
            if (acc0) begin
                open_port = s0_if.tlast ? -1 : 0;
                if (s0_if.tlast) s0_last_cyc = cyc;
            end
            if (acc1) begin
                open_port = s1_if.tlast ? -1 : 1;
                if (s1_first_cyc < 0) begin
                    s1_first_cyc = cyc;
                    first_grant1 = grant;
                end
            end
            if (got_q.size() >= n_beats && q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
            #1;
            if (acc0) begin
                void'(q0.pop_front());
                pres0 = 0;
                sent0++;
                if (sent0 == pause_at0) pause_cnt0 = pause_len0;
            end
            if (acc1) begin
                void'(q1.pop_front());
                pres1 = 0;
                sent1++;
            end
            if (!pres0) begin
                if (pause_cnt0 > 0) pause_cnt0--;
                else if (q0.size() > 0 && $urandom_range(0, 99) >= gap0_pct) pres0 = 1;
            end
            if (!pres1 && q1.size() > 0 && $urandom_range(0, 99) >= gap1_pct) pres1 = 1;
            drive_ports();
            if (rdy_pct < 0) m_if.tready = ~m_if.tready;
            else             m_if.tready = ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_bench();
        s0_if.tvalid = 1; s1_if.tvalid = 1; s0_if.tdata = '1; s1_if.tlast = 1;
        repeat (2) @(negedge clk);
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (cur_m() !== beat_t'(0)) begin n_bad++; $display("FAIL rst_out_reg: got %h want 0", cur_m()); end
        n_cmp++; if (s0_if.tready !== 1'b0) begin n_bad++; $display("FAIL rst_s0_ready: got %b want 0", s0_if.tready); end
        n_cmp++; if (s1_if.tready !== 1'b0) begin n_bad++; $display("FAIL rst_s1_ready: got %b want 0", s1_if.tready); end
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", grant); end
        s0_if.tvalid = 0; s1_if.tvalid = 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL idle_grant: got %b want 00", grant); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        beat_t b0, b1;
        do_reset();
        b0 = mk_beat(1, 0, 0, 0); b0.keep = 32'hffffffff;
        b1 = mk_beat(1, 0, 1, 1); b1.keep = 32'h0002ffff;
        q1.push_back(b0); q1.push_back(b1);
        run_cycles(20, 2);
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL t1_count: got %0d want 2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[0] !== b0) begin n_bad++; $display("FAIL t1_beat0: got %h want %h", got_q[0], b0); end
            n_cmp++; if (got_q[1] !== b1) begin n_bad++; $display("FAIL t1_beat1: got %h want %h", got_q[1], b1); end
            n_cmp++; if (got_cyc[0] != 3) begin n_bad++; $display("FAIL t1_latency: got %0d want 3", got_cyc[0]); end
            n_cmp++; if (got_cyc[1] != 4) begin n_bad++; $display("FAIL t1_beat1_cycle: got %0d want 4", got_cyc[1]); end
        end
        n_cmp++; if (first_grant1 !== 2'b10) begin n_bad++; $display("FAIL t1_grant: got %b want 10", first_grant1); end
        n_cmp++; if (proto_bad != 0) begin n_bad++; $display("FAIL t1_protocol: got %0d want 0", proto_bad); end
        $display("test_single_frame: %0d beats", got_q.size());
    endtask

    task automatic test_round_robin();
        int want_d;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            gen_frame(0, f, 2, 1);
            gen_frame(1, f, 2, 1);
        end
        run_cycles(300, exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rr_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            if (i > 0) begin
                want_d = exp_q[i-1].last ? EXP_BUBBLE + 1 : 1;
                n_cmp++;
                if (got_cyc[i] - got_cyc[i-1] != want_d) begin
                    n_bad++; $display("FAIL rr_spacing%0d: got %0d want %0d", i, got_cyc[i] - got_cyc[i-1], want_d);
                end
            end
        end
        n_cmp++; if (proto_bad != 0) begin n_bad++; $display("FAIL rr_protocol: got %0d want 0", proto_bad); end
        $display("test_round_robin: %0d beats", got_q.size());
    endtask

    task automatic test_backpressure();
        do_reset();
        gen_frame(0, 0, 3, 1);
        rdy_pct = -1;
        run_cycles(60, 3);
        n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (stall_chk < 1) begin n_bad++; $display("FAIL bp_stalls_seen: got %0d want >0", stall_chk); end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable want 0", stall_bad); end
        m_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", m_if.tvalid); end
        $display("test_backpressure: %0d beats, %0d stalled cycles", got_q.size(), stall_chk);
    endtask

    task automatic test_stall_block();
        do_reset();
        gen_frame(0, 0, 3, 1);
        gen_frame(1, 0, 2, 1);
        pause_at0 = 2; pause_len0 = 5;
        run_cycles(100, exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL blk_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL blk_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (s1_first_cyc - s0_last_cyc != EXP_BUBBLE + 1) begin
            n_bad++; $display("FAIL blk_s1_start: got %0d want %0d", s1_first_cyc - s0_last_cyc, EXP_BUBBLE + 1);
        end
        n_cmp++; if (proto_bad != 0) begin n_bad++; $display("FAIL blk_protocol: got %0d want 0", proto_bad); end
        $display("test_stall_block: s0 tlast cycle %0d, s1 first cycle %0d", s0_last_cyc, s1_first_cyc);
    endtask

    task automatic test_reset_midframe();
        do_reset();
        gen_frame(0, 0, 3, 0);
        run_cycles(30, 2);
        n_cmp++; if (m_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL mr_pre_valid: got %b want 1", m_if.tvalid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL mr_tvalid: got %b want 0", m_if.tvalid); end
        n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL mr_grant: got %b want 00", grant); end
        clear_bench();
        @(negedge clk);
        rst_n = 1'b1;
        gen_frame(0, 1, 2, 1);
        gen_frame(1, 1, 2, 1);
        run_cycles(100, exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL mr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mr_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        $display("test_reset_midframe: %0d beats after restart", got_q.size());
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 5; f++) begin
            gen_frame(0, f, $urandom_range(1, 4), 1);
            gen_frame(1, f, $urandom_range(1, 4), 1);
        end
        rdy_pct = 50;
        run_cycles(1000, exp_q.size());
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL b2b_stable: got %0d want 0", stall_bad); end
        n_cmp++; if (proto_bad != 0) begin n_bad++; $display("FAIL b2b_protocol: got %0d want 0", proto_bad); end
        $display("test_back_to_back: %0d beats", got_q.size());
    endtask

    task automatic test_random_gaps();
        beat_t eq0[$];
        beat_t eq1[$];
        beat_t want;
        int    cur, p, total;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            gen_frame(0, f, $urandom_range(1, 4), 0);
            gen_frame(1, f, $urandom_range(1, 4), 0);
        end
        eq0 = q0; eq1 = q1;
        total = q0.size() + q1.size();
        gap0_pct = 30; gap1_pct = 40; rdy_pct = 60;
        run_cycles(3000, total);
        n_cmp++; if (got_q.size() != total) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), total); end
        cur = -1;
        for (int i = 0; i < got_q.size(); i++) begin
            p = int'(got_q[i].user[UW-1]);
            n_cmp++;
            if (cur >= 0 && p != cur) begin
                n_bad++; $display("FAIL rnd_interleave: beat %0d from port %0d want port %0d", i, p, cur);
            end
            want = '0;
            if (p == 0 && eq0.size() > 0) want = eq0.pop_front();
            else if (p == 1 && eq1.size() > 0) want = eq1.pop_front();
            n_cmp++; if (got_q[i] !== want) begin n_bad++; $display("FAIL rnd_beat%0d: got %h want %h", i, got_q[i], want); end
            cur = got_q[i].last ? -1 : p;
        end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL rnd_stable: got %0d want 0", stall_bad); end
        n_cmp++; if (proto_bad != 0) begin n_bad++; $display("FAIL rnd_protocol: got %0d want 0", proto_bad); end
        $display("test_random_gaps: %0d beats", got_q.size());
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_stall_block();
        test_reset_midframe();
        test_back_to_back();
        test_random_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
